// File: rtl/instr_loader_pkg.sv
// Shared types and default control words for the program loader.
package instr_loader_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Terminator and restart words, matching the assembler-side tools.
  localparam logic [15:0] DEF_END_INSTR     = 16'hFFFF;
  localparam logic [15:0] DEF_RESTART_INSTR = 16'hFFFE;

endpackage

// File: rtl/instr_loader.sv
// Program loader: writes received instructions to consecutive memory addresses and holds the CPU in reset while loading.
// Optional running checksum of written words is enabled by defining LOADER_CHECKSUM_EN.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int                 ADDR_W        = 8,
  parameter int                 DATA_W        = 16,
  parameter logic [DATA_W-1:0]  END_INSTR     = DATA_W'(DEF_END_INSTR),
  parameter logic [DATA_W-1:0]  RESTART_INSTR = DATA_W'(DEF_RESTART_INSTR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rx_dv,
  input  logic [DATA_W-1:0] i_rx_instr,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_cpu_rst,
  output logic              o_load_done,
  output logic              o_full,
  output logic [ADDR_W:0]   o_count,
  output logic [15:0]       o_checksum
);

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_cpu_rst;
  logic              r_done;
  logic              r_full;
  logic [ADDR_W:0]   r_count;

  logic w_loading;
  logic w_is_end;
  logic w_write;
  logic w_restart;

  assign w_loading = (r_state != ST_DONE);
  assign w_is_end  = (i_rx_instr == END_INSTR);
  assign w_write   = w_loading && i_rx_dv && !w_is_end;
  assign w_restart = !w_loading && i_rx_dv && (i_rx_instr == RESTART_INSTR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_WAIT;
      r_ptr     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_cpu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_full    <= 1'b0;
      r_count   <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_WAIT, ST_LOAD: begin
          if (w_write) begin
            r_we    <= 1'b1;
            r_addr  <= r_ptr;
            r_data  <= i_rx_instr;
            r_count <= r_count + 1'b1;
            // Last slot written: stop here rather than wrap the pointer.
            if (r_ptr == PTR_MAX) begin
              r_state   <= ST_DONE;
              r_full    <= 1'b1;
              r_cpu_rst <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_ptr   <= r_ptr + 1'b1;
              r_state <= ST_LOAD;
            end
          end else if (i_rx_dv) begin
            r_state   <= ST_DONE;
            r_cpu_rst <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        ST_DONE: begin
          if (w_restart) begin
            r_state   <= ST_WAIT;
            r_ptr     <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_done    <= 1'b0;
            r_cpu_rst <= 1'b1;
          end
        end
        default: r_state <= ST_WAIT;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_checksum <= '0;
    end else if (w_restart) begin
      r_checksum <= '0;
    end else if (w_write) begin
      r_checksum <= r_checksum + 16'(i_rx_instr);
    end
  end

  assign o_checksum = r_checksum;
`else
  assign o_checksum = '0;
`endif

  assign o_mem_we    = r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_data  = r_data;
  assign o_cpu_rst   = r_cpu_rst;
  assign o_load_done = r_done;
  assign o_full      = r_full;
  assign o_count     = r_count;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader (ADDR_W=4): directed scenarios followed by randomized word streams.
module tb_instr_loader;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_rx_dv = 1'b0;
  logic [15:0]   i_rx_instr = '0;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [15:0]   o_mem_data;
  logic          o_cpu_rst;
  logic          o_load_done;
  logic          o_full;
  logic [AW:0]   o_count;
  logic [15:0]   o_checksum;

  instr_loader #(.ADDR_W(AW), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .i_rx_dv(i_rx_dv), .i_rx_instr(i_rx_instr),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .o_cpu_rst(o_cpu_rst), .o_load_done(o_load_done), .o_full(o_full),
    .o_count(o_count), .o_checksum(o_checksum)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; int cyc; } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  int cyc  = 0;
  int nchk = 0;
  int nerr = 0;

  // Reference model: the words written so far in the current load.
  int m_words[$];
  bit m_done = 0;
  bit m_full = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc > 20000) begin
      $display("FAIL watchdog: cycle=%0d limit=20000", cyc);
      $fatal(1);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int m_sum();
    int s = 0;
`ifdef LOADER_CHECKSUM_EN
    foreach (m_words[i]) s = (s + m_words[i]) % 65536;
`endif
    return s;
  endfunction

  task automatic model(input int w);
    wr_t e;
    if (m_done) begin
      if (w == 16'hFFFE) begin
        m_done = 0;
        m_full = 0;
        m_words.delete();
      end
    end else if (w == 16'hFFFF) begin
      m_done = 1;
    end else begin
      e.addr = m_words.size();
      e.data = w;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
      m_words.push_back(w);
      if (m_words.size() == DEPTH) begin
        m_done = 1;
        m_full = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst && o_mem_we) begin
      if (exp_q.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_write: actual addr=0x%0h data=0x%0h required no write (cycle %0d)",
                 o_mem_addr, o_mem_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", int'(o_mem_addr), mon_e.addr);
        chk("wr_data", int'(o_mem_data), mon_e.data);
        chk("wr_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Called at posedge+1: present word for the next edge, then leave at posedge+1.
  task automatic drive(input int w);
    i_rx_dv    = 1'b1;
    i_rx_instr = 16'(w);
    model(w);
    @(posedge clk); #1;
    i_rx_dv = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic status(input string nm);
    chk({nm, "_count"},    int'(o_count),     m_words.size());
    chk({nm, "_cpu_rst"},  int'(o_cpu_rst),   int'(!m_done));
    chk({nm, "_done"},     int'(o_load_done), int'(m_done));
    chk({nm, "_full"},     int'(o_full),      int'(m_full));
    chk({nm, "_checksum"}, int'(o_checksum),  m_sum());
    chk({nm, "_pending"},  exp_q.size(),      0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_we",       int'(o_mem_we),    0);
    chk("rst_addr",     int'(o_mem_addr),  0);
    chk("rst_data",     int'(o_mem_data),  0);
    chk("rst_cpu_rst",  int'(o_cpu_rst),   1);
    chk("rst_done",     int'(o_load_done), 0);
    chk("rst_full",     int'(o_full),      0);
    chk("rst_count",    int'(o_count),     0);
    chk("rst_checksum", int'(o_checksum),  0);
    m_words.delete();
    m_done = 0;
    m_full = 0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int r;
  int w;

  initial begin
    @(posedge clk); #1;
    do_reset();

    drive(16'hAB37); drive(16'h1234); drive(16'hFFFF);
    idle(2);
    status("t1");
`ifdef LOADER_CHECKSUM_EN
    chk("t1_sum_const", int'(o_checksum), 16'hBD6B);
`endif

    drive(16'h5555); idle(2); status("t4_ignore");
    drive(16'hFFFE); idle(2); status("t4_restart");
    drive(16'h0001); idle(2); status("t4_after");

    do_reset();
    drive(16'hFFFF); idle(2); status("t6");

    do_reset();
    drive(16'h1111); drive(16'h2222); drive(16'h3333);
    idle(2); status("t3");

    do_reset();
    drive(16'h0A0A); drive(16'h0B0B);
    idle(2);
    do_reset();
    drive(16'h7777); idle(2); status("t5");

    do_reset();
    for (int i = 0; i < DEPTH; i++) drive(int'($urandom_range(0, 16'hFFFE)));
    idle(2); status("t2_full");
    drive(16'h4242); idle(2); status("t2_ignored");

    do_reset();
    for (int it = 0; it < 400; it++) begin
      idle(int'($urandom_range(0, 2)));
      r = int'($urandom_range(0, 15));
      if (r == 0)      w = 16'hFFFF;
      else if (r <= 2) w = 16'hFFFE;
      else             w = int'($urandom_range(0, 16'hFFFF));
      drive(w);
      if (it % 25 == 24) begin
        idle(2);
        status("rand");
      end
      if ($urandom_range(0, 99) == 0) begin
        idle(2);
        do_reset();
      end
    end
    idle(3);
    status("final");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
